// File: rtl/registro_file.sv
// registro_file: DEPTH x WIDTH register bank, one byte-lane write port,
// two registered read ports, per-entry valid flags and a valid-entry count.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (bank, flags, count, read regs)
//   cl         synchronous clear-all of bank, flags and count
//   w          write strobe, waddr write address, be byte enables, din data
//   raddr_a/b  read addresses; dout_a/b, vout_a/b registered read results
//   valid_cnt  number of entries with their valid flag set
//
// Optional build macro:
//   REGISTRO_FILE_BYPASS_EN  forward same-edge writes to the read ports
module registro_file #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cl,
  input  logic                w,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [WIDTH/8-1:0]  be,
  input  logic [WIDTH-1:0]    din,
  input  logic [ADDR_W-1:0]   raddr_a,
  input  logic [ADDR_W-1:0]   raddr_b,
  output logic [WIDTH-1:0]    dout_a,
  output logic                vout_a,
  output logic [WIDTH-1:0]    dout_b,
  output logic                vout_b,
  output logic [ADDR_W:0]     valid_cnt
);

  localparam int LANES = WIDTH / 8;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [ADDR_W:0]  cnt_q;

  logic [WIDTH-1:0] dout_a_q, dout_b_q;
  logic             vout_a_q, vout_b_q;

  logic             wr_ok;
  logic [WIDTH-1:0] old_w;
  logic [WIDTH-1:0] merged;
  logic [WIDTH:0]   rd_a_d, rd_b_d;

  // Write path: accepted only for in-range addresses.
  always_comb begin
    wr_ok  = w && (int'(waddr) < DEPTH);
    old_w  = wr_ok ? mem_q[waddr] : '0;
    merged = old_w;
    for (int i = 0; i < LANES; i++) begin
      if (be[i]) merged[8*i +: 8] = din[8*i +: 8];
    end
  end

  // Read lookup returns {valid, data} for one address.
  function automatic logic [WIDTH:0] rd_lookup(
    input logic [ADDR_W-1:0] a
  );
    logic [WIDTH:0] r;
    r = '0;
    if (int'(a) < DEPTH) r = {vld_q[a], mem_q[a]};
`ifdef REGISTRO_FILE_BYPASS_EN
    if (wr_ok && (a == waddr)) r = {1'b1, merged};
    if (cl) r = '0;
`endif
    return r;
  endfunction

  always_comb begin
    rd_a_d = rd_lookup(raddr_a);
    rd_b_d = rd_lookup(raddr_b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      vld_q    <= '0;
      cnt_q    <= '0;
      dout_a_q <= '0;
      vout_a_q <= 1'b0;
      dout_b_q <= '0;
      vout_b_q <= 1'b0;
    end else begin
      dout_a_q <= rd_a_d[WIDTH-1:0];
      vout_a_q <= rd_a_d[WIDTH];
      dout_b_q <= rd_b_d[WIDTH-1:0];
      vout_b_q <= rd_b_d[WIDTH];
      if (cl) begin
        for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        vld_q <= '0;
        cnt_q <= '0;
      end else if (wr_ok) begin
        mem_q[waddr] <= merged;
        vld_q[waddr] <= 1'b1;
        // count only 0->1 flag transitions, so it can never exceed DEPTH
        if (!vld_q[waddr]) cnt_q <= cnt_q + {{ADDR_W{1'b0}}, 1'b1};
      end
    end
  end

  assign dout_a    = dout_a_q;
  assign vout_a    = vout_a_q;
  assign dout_b    = dout_b_q;
  assign vout_b    = vout_b_q;
  assign valid_cnt = cnt_q;

endmodule

// File: tb/tb_registro_file.sv
// tb_registro_file: checks registro_file (DEPTH=8 and DEPTH=6 instances)
// against an array model plus literal expectations.
module tb_registro_file;

  logic        clk = 1'b0;
  logic        rst, cl, w;
  logic [2:0]  waddr, ra, rb;
  logic [3:0]  be;
  logic [31:0] din;

  logic [31:0] da0, db0, da1, db1;
  logic        va0, vb0, va1, vb1;
  logic [3:0]  cnt0, cnt1;

  always #5 clk = ~clk;

  registro_file #(.WIDTH(32), .DEPTH(8), .ADDR_W(3)) u8 (
    .clk(clk), .rst(rst), .cl(cl), .w(w), .waddr(waddr), .be(be),
    .din(din), .raddr_a(ra), .raddr_b(rb),
    .dout_a(da0), .vout_a(va0), .dout_b(db0), .vout_b(vb0),
    .valid_cnt(cnt0)
  );

  registro_file #(.WIDTH(32), .DEPTH(6), .ADDR_W(3)) u6 (
    .clk(clk), .rst(rst), .cl(cl), .w(w), .waddr(waddr), .be(be),
    .din(din), .raddr_a(ra), .raddr_b(rb),
    .dout_a(da1), .vout_a(va1), .dout_b(db1), .vout_b(vb1),
    .valid_cnt(cnt1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", n, act, exp);
    end
  endtask

  // model state per instance
  logic [31:0] mm [2][8];
  bit          mv [2][8];
  logic [31:0] e_da [2], e_db [2];
  bit          e_va [2], e_vb [2];
  int          e_cnt [2];
  bit          live = 0;

  function automatic int dep(int k);
    return (k == 0) ? 8 : 6;
  endfunction

  function automatic logic [31:0] mrg(logic [31:0] old);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = din[8*i +: 8];
    return r;
  endfunction

  function automatic logic [32:0] mread(int k, logic [2:0] a);
    if (int'(a) >= dep(k)) return 33'd0;
`ifdef REGISTRO_FILE_BYPASS_EN
    if (cl) return 33'd0;
    if (w && int'(waddr) < dep(k) && a == waddr)
      return {1'b1, mrg(mm[k][a])};
`endif
    return {mv[k][a], mm[k][a]};
  endfunction

  task automatic step(input logic r, input logic c, input logic ww,
                      input logic [2:0] wa, input logic [3:0] b,
                      input logic [31:0] d,
                      input logic [2:0] xa, input logic [2:0] xb);
    logic [32:0] pa [2], pb [2];
    int          pc [2];
    rst = r; cl = c; w = ww; waddr = wa; be = b; din = d;
    ra = xa; rb = xb;
    for (int k = 0; k < 2; k++) begin
      pa[k] = r ? 33'd0 : mread(k, xa);
      pb[k] = r ? 33'd0 : mread(k, xb);
      if (r || c) begin
        for (int j = 0; j < 8; j++) begin
          mm[k][j] = '0;
          mv[k][j] = 0;
        end
      end else if (ww && int'(wa) < dep(k)) begin
        mm[k][wa] = mrg(mm[k][wa]);
        mv[k][wa] = 1;
      end
      pc[k] = 0;
      for (int j = 0; j < 8; j++) pc[k] += int'(mv[k][j]);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      e_da[k] = pa[k][31:0];
      e_va[k] = pa[k][32];
      e_db[k] = pb[k][31:0];
      e_vb[k] = pb[k][32];
      e_cnt[k] = pc[k];
    end
    live = 1;
    @(negedge clk);
  endtask

  task automatic rd(input logic [2:0] xa, input logic [2:0] xb);
    step(0, 0, 0, 3'd0, 4'h0, 32'h0, xa, xb);
  endtask

  always @(negedge clk) begin
    if (live) begin
      chk("d8_dout_a", da0, e_da[0]);
      chk("d8_vout_a", {31'd0, va0}, {31'd0, e_va[0]});
      chk("d8_dout_b", db0, e_db[0]);
      chk("d8_vout_b", {31'd0, vb0}, {31'd0, e_vb[0]});
      chk("d8_cnt", {28'd0, cnt0}, e_cnt[0]);
      chk("d6_dout_a", da1, e_da[1]);
      chk("d6_vout_a", {31'd0, va1}, {31'd0, e_va[1]});
      chk("d6_dout_b", db1, e_db[1]);
      chk("d6_vout_b", {31'd0, vb1}, {31'd0, e_vb[1]});
      chk("d6_cnt", {28'd0, cnt1}, e_cnt[1]);
    end
  end

  initial begin
    rst = 1; cl = 0; w = 0; waddr = 0; be = 0; din = 0; ra = 0; rb = 0;
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 8; j++) begin
        mm[k][j] = 'x;
        mv[k][j] = 0;
      end
    @(negedge clk);
    step(1, 0, 0, 3'd0, 4'h0, 32'h0, 3'd0, 3'd0);
    step(1, 0, 0, 3'd0, 4'h0, 32'h0, 3'd0, 3'd0);
    chk("lit_rst_cnt", {28'd0, cnt0}, 32'd0);
    chk("lit_rst_dout", da0, 32'h0);

    for (int i = 0; i < 8; i++) rd(3'(i), 3'(7 - i));
    chk("lit_empty_va", {31'd0, va0}, 32'd0);

    // byte-lane merge
    step(0, 0, 1, 3'd3, 4'hF, 32'hDEADBEEF, 3'd0, 3'd0);
    step(0, 0, 1, 3'd3, 4'h2, 32'h00005500, 3'd0, 3'd0);
    rd(3'd3, 3'd3);
    chk("lit_merge_a", da0, 32'hDEAD55EF);
    chk("lit_merge_b", db0, 32'hDEAD55EF);
    chk("lit_merge_v", {31'd0, va0}, 32'd1);
    chk("lit_merge_cnt", {28'd0, cnt0}, 32'd1);

    // fill all entries, count steps, then clear
    step(0, 1, 0, 3'd0, 4'h0, 32'h0, 3'd3, 3'd0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 3'(i), 4'hF, 32'hC0DE0000 + i, 3'(i), 3'(i - 1));
      chk("lit_fill_cnt", {28'd0, cnt0}, i + 1);
    end
    step(0, 0, 1, 3'd5, 4'h1, 32'h000000AB, 3'd5, 3'd4);
    chk("lit_rewrite_cnt", {28'd0, cnt0}, 32'd8);
    chk("lit_d6_full_cnt", {28'd0, cnt1}, 32'd6);
    rd(3'd5, 3'd7);
    chk("lit_rewrite_d", da0, 32'hC0DE00AB);
    step(0, 1, 0, 3'd0, 4'h0, 32'h0, 3'd5, 3'd1);
    chk("lit_clr_cnt", {28'd0, cnt0}, 32'd0);
    for (int i = 0; i < 8; i++) rd(3'(i), 3'(i));
    chk("lit_clr_va", {31'd0, va0}, 32'd0);

    // same-edge write and read
    step(0, 0, 1, 3'd2, 4'hF, 32'hAAAAAAAA, 3'd0, 3'd0);
    step(0, 0, 1, 3'd2, 4'hF, 32'h12345678, 3'd2, 3'd2);
`ifdef REGISTRO_FILE_BYPASS_EN
    chk("lit_fwd", da0, 32'h12345678);
`else
    chk("lit_fwd", da0, 32'hAAAAAAAA);
`endif
    rd(3'd2, 3'd2);
    chk("lit_after_fwd", da0, 32'h12345678);

    // partial lane write with forwarding, clear with write pending
    step(0, 0, 1, 3'd2, 4'h9, 32'hFF0000EE, 3'd2, 3'd6);
    rd(3'd2, 3'd6);
    chk("lit_lane9", da0, 32'hFF3456EE);
    step(0, 1, 1, 3'd4, 4'hF, 32'h55555555, 3'd2, 3'd4);
    rd(3'd4, 3'd2);
    chk("lit_clr_beats_w", {28'd0, cnt0}, 32'd0);

    // out-of-range on DEPTH=6
    step(0, 0, 1, 3'd1, 4'hF, 32'h01010101, 3'd1, 3'd0);
    step(0, 0, 1, 3'd7, 4'hF, 32'h77777777, 3'd7, 3'd6);
    chk("lit_d6_oor_cnt", {28'd0, cnt1}, 32'd1);
    rd(3'd6, 3'd7);
    chk("lit_d6_rd6", da1, 32'h0);
    chk("lit_d6_rd6_v", {31'd0, va1}, 32'd0);
    chk("lit_d8_rd7", db0, 32'h77777777);
    step(0, 0, 1, 3'd0, 4'h0, 32'hFFFFFFFF, 3'd0, 3'd0);
    rd(3'd0, 3'd0);
    chk("lit_be0_v", {31'd0, va0}, 32'd1);

    // reset beats write
    step(1, 0, 1, 3'd1, 4'hF, 32'h11111111, 3'd1, 3'd7);
    chk("lit_rst_out", da0, 32'h0);
    rd(3'd1, 3'd7);
    chk("lit_rst_e1", da0, 32'h0);
    chk("lit_rst_cnt2", {28'd0, cnt0}, 32'd0);

    live = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
